demux_1_5_stream: RTL



---
 rtl/demux_1_5_stream_pkg.sv | 12 +
 rtl/demux_1_5_stream_if.sv | 31 +++
 rtl/demux_1_5_stream_ch_slot.sv | 48 ++++
 rtl/demux_1_5_stream.sv | 69 ++++++
 4 files changed

// File: rtl/demux_1_5_stream_pkg.sv
// Shared constants, channel state type and select helper for the 1:5 stream demux.
package demux_pkg;
    localparam int N_CH  = 5;
    localparam int SEL_W = 3;

    typedef enum logic {CH_EMPTY, CH_FULL} ch_state_t;

    // Selects at or above N_CH address no channel; such beats are dropped.
    function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel);
        return sel < SEL_W'(N_CH);
    endfunction
endpackage

// File: rtl/demux_1_5_stream_if.sv
// Producer/consumer bundle for demux_1_5_stream.
//   in_valid/in_ready/in_data/in_sel : single producer side
//   out_valid/out_ready/out_data     : N_CH consumer channels, channel k at [k*DATA_W +: DATA_W]
//   drop_pulse/drop_cnt              : invalid-select drop reporting
// slave modport is the demux view, master is the environment view.
interface demux_1_5_stream_if
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic                   drop_pulse;
    logic [CNT_W-1:0]       drop_cnt;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_pulse, drop_cnt
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_pulse, drop_cnt
    );
endinterface

// File: rtl/demux_1_5_stream_ch_slot.sv
// One-entry holding slot for a single output channel.
//   clk, rst   : clock, async active-high reset
//   load       : capture load_data this cycle
//   load_data  : beat to capture
//   out_ready  : consumer takes the held beat
//   out_valid  : slot full
//   out_data   : held beat; keeps its last value after drain
module demux_ch_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    ch_state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CH_EMPTY;
        else     state_q <= state_d;
    end

    // A load while full and draining stays FULL: the new beat replaces the old one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_EMPTY: if (load)                state_d = CH_FULL;
            CH_FULL:  if (out_ready && !load)  state_d = CH_EMPTY;
            default:                           state_d = CH_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == CH_FULL);
    end

    // Upstream only loads when the slot is empty or draining, so data never
    // changes under a stalled valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       out_data <= '0;
        else if (load) out_data <= load_data;
    end
endmodule

// File: rtl/demux_1_5_stream.sv
// Registered 1:5 stream demultiplexer.
//   clk, rst : clock, async active-high reset
//   bus      : demux_1_5_stream_if slave modport (input beat + select, five
//              output channels with valid/ready, drop pulse and saturating count)
// A beat whose select names no channel is always accepted, dropped and counted.
module demux_1_5_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1_5_stream_if.slave    bus
);
    localparam int SEL_SPAN = 2**SEL_W;

    logic                          sel_ok;
    logic                          accept;
    logic                          drop;
    logic [SEL_SPAN-1:0]           vld_pad;
    logic [SEL_SPAN-1:0]           rdy_pad;
    logic [N_CH-1:0]               load;
    logic [N_CH-1:0]               ch_vld;
    logic [N_CH-1:0][DATA_W-1:0]   ch_data;
    logic                          drop_pulse_q;
    logic [CNT_W-1:0]              drop_cnt_q;

    assign sel_ok = sel_is_valid(bus.in_sel);

    // Zero-extend to the full select range so any in_sel indexes in bounds.
    assign vld_pad = SEL_SPAN'(ch_vld);
    assign rdy_pad = SEL_SPAN'(bus.out_ready);

    // Only the destination slot can stall a beat.
    assign bus.in_ready = sel_ok ? (!vld_pad[bus.in_sel] || rdy_pad[bus.in_sel]) : 1'b1;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drop         = accept && !sel_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign load[k] = accept && sel_ok && (bus.in_sel == SEL_W'(k));

        demux_ch_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_valid (ch_vld[k]),
            .out_data  (ch_data[k])
        );
    end

    assign bus.out_valid = ch_vld;
    assign bus.out_data  = ch_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            drop_pulse_q <= drop;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.drop_pulse = drop_pulse_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule
